alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU. Decodes the main-decoder `alu_op` and `{funct7[5],funct3}` into an operation code, evaluates it, and registers the result behind a valid/ready handshake.
- Adds an optional iterative multi-cycle multiplier and a pipeline flush.
- Sits between the ID/EX register and EX/MEM in the pipelined core. It replaces the combinational op-decode-plus-ALU pair.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2 and at least 8.
- SHAMT_W, $clog2(WIDTH), number of shift-amount bits taken from `b`.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous squash of in-flight and held results.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept this cycle.
- alu_op  in  2  00=ADD (ld/st), 01=SUB (branch), 10=R-type, 11=I-type.
- func  in  4  {funct7[5], funct3}.
- is_mul  in  1  M-extension MUL request (funct7[0] of an R-type).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result registered and valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered; op undecodable; result forced to 0.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; out_valid=0, result=0, zero=0, illegal=0; multiplier counter and accumulator cleared. Reset has priority over flush and all handshakes.
- Accept rule: accept = in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready). In this way an output can be drained and a new op accepted in the same cycle.
- Decode, alu_op=00 or 01: ADD or SUB respectively; func ignored.
- Decode, alu_op=10 (func → op): 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. Any other func → illegal.
- Decode, alu_op=11: func[2:0] decoded as in R-type with func[3]=0, except 101, where func[3] selects SRA (1) or SRL (0).
- Operation codes: AND=0000, OR=0001, ADD=0010 and SUB=0110 keep their legacy values. New ops take 0011, 0100, 0101, 0111, 1000, 1001.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare and SLTU unsigned; both return 0 or 1 zero-extended.
  - Shift amount = b[SHAMT_W-1:0]; SRA sign-fills.
- Single-cycle ops: accepted at edge N; result, zero, illegal and out_valid=1 are updated at edge N. Output holds until out_ready=1.
- FSM (states IDLE, MUL_BUSY):
  - IDLE → MUL_BUSY on accept with is_mul=1 and alu_op=10; operands latched; counter=WIDTH-1; out_valid cleared at that edge.
  - MUL_BUSY: one shift-add iteration per cycle; in_ready=0.
  - MUL_BUSY → IDLE when the counter hits 0. At that edge: result = low WIDTH bits of a*b, out_valid=1. Latency from accept edge to out_valid = WIDTH cycles.
- Back-pressure: out_valid=1 & out_ready=0 holds result/zero/illegal stable; in_ready=0.
- flush=1 at an edge: out_valid=0, state=IDLE, multiplier aborted; any accept in that cycle is discarded. result/zero/illegal keep their last value.
- Simultaneous out_ready and accept: the old result is consumed and the new result is loaded at the same edge.
- is_mul with alu_op≠10 is ignored; the op is decoded normally.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: multiplier datapath and MUL_BUSY state are present, as specified above.
- Undefined: no multiplier logic. An accept with is_mul=1 and alu_op=10 completes in one cycle with result=0, zero=1, illegal=1. The FSM is reduced to IDLE only.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (ADD, SUB, RTYPE, ITYPE);
  - alu_opcode_e 4-bit operation enum with the codes above;
  - exec_state_e (IDLE, MUL_BUSY);
  - the default WIDTH constant.
- Sub-module alu_op_decode: purely combinational; inputs alu_op, func; outputs opcode and illegal. It is the direct successor of the legacy op decoder.

Test Plan (WIDTH=32):
1. alu_op=10, func=1000, a=5, b=7 → next edge out_valid=1, result=32'hFFFF_FFFE, zero=0, illegal=0.
2. alu_op=11, func=1101, a=32'h8000_0000, b=4 → result=32'hF800_0000. Repeat with func=0101 → result=32'h0800_0000.
3. alu_op=10, func=0010, a=-1, b=1 → result=1. Same operands with func=0011 → result=0, zero=1.
4. alu_op=10, func=1111 → illegal=1, result=0. Then hold out_ready=0 for 3 cycles → outputs stable, in_ready=0.
5. ALU_MUL_EN defined, is_mul=1, a=1234, b=5678:
   - out_valid rises exactly 32 cycles after accept, result=7006652, in_ready=0 throughout.
   - Repeat with flush asserted at cycle 10 → out_valid stays 0, in_ready=1 next cycle.
6. rst_n=0 asserted mid-MUL and while out_valid=1 → after the edge all outputs are 0 and in_ready=1. Back-to-back accepts with out_ready=1 sustain 1 result per cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  // AND/OR/ADD/SUB keep the legacy encodings so older decode tables still line up.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SLT  = 4'b0100,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001
  } alu_opcode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exec_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decoder: {alu_op, funct7[5], funct3} -> ALU opcode plus illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [3:0]  func,
  output alu_opcode_e opcode,
  output logic        illegal
);

  always_comb begin
    opcode  = OP_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: opcode = OP_ADD;
      ALU_SUB: opcode = OP_SUB;
      ALU_RTYPE: begin
        case (func)
          4'b0000: opcode = OP_ADD;
          4'b1000: opcode = OP_SUB;
          4'b0001: opcode = OP_SLL;
          4'b0010: opcode = OP_SLT;
          4'b0011: opcode = OP_SLTU;
          4'b0100: opcode = OP_XOR;
          4'b0101: opcode = OP_SRL;
          4'b1101: opcode = OP_SRA;
          4'b0110: opcode = OP_OR;
          4'b0111: opcode = OP_AND;
          default: illegal = 1'b1;
        endcase
      end
      ALU_ITYPE: begin
        // Immediates have no SUB; bit 3 only matters to pick SRA over SRL.
        case (func[2:0])
          3'b000:  opcode = OP_ADD;
          3'b001:  opcode = OP_SLL;
          3'b010:  opcode = OP_SLT;
          3'b011:  opcode = OP_SLTU;
          3'b100:  opcode = OP_XOR;
          3'b101:  opcode = func[3] ? OP_SRA : OP_SRL;
          3'b110:  opcode = OP_OR;
          default: opcode = OP_AND;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered valid/ready output; single-cycle ops land at the accept edge,
// MUL (only when ALU_MUL_EN is defined) takes WIDTH cycles. A held, unconsumed result blocks in_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       func,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_opcode_e        opcode;
  logic               dec_illegal;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   sc_res;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               mul_req;
  exec_state_e        state, state_nxt;

  alu_op_decode u_dec (
    .alu_op  (alu_op),
    .func    (func),
    .opcode  (opcode),
    .illegal (dec_illegal)
  );

  assign shamt    = b[SHAMT_W-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_req  = is_mul && (alu_op == ALU_RTYPE);

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign sc_res = dec_illegal ? '0 : alu_res;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_acc_nxt;
  logic [SHAMT_W-1:0] mul_cnt;

  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
`endif

  always_comb begin
    state_nxt = state;
`ifdef ALU_MUL_EN
    case (state)
      IDLE:     if (accept && mul_req) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
`endif
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (mul_req) begin
`ifdef ALU_MUL_EN
          mul_a     <= a;
          mul_b     <= b;
          mul_acc   <= '0;
          mul_cnt   <= SHAMT_W'(WIDTH - 1);
          out_valid <= 1'b0;
`else
          result    <= '0;
          zero      <= 1'b1;
          illegal   <= 1'b1;
          out_valid <= 1'b1;
`endif
        end else begin
          result    <= sc_res;
          zero      <= (sc_res == '0);
          illegal   <= dec_illegal;
          out_valid <= 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      // One multiplier bit per cycle, LSB first; the last bit folds straight into result.
      if (state == MUL_BUSY) begin
        if (mul_cnt == '0) begin
          result    <= mul_acc_nxt;
          zero      <= (mul_acc_nxt == '0);
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end else begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt - 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); MUL checks follow ALU_MUL_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, is_mul;
  logic [1:0]  alu_op;
  logic [3:0]  func;
  logic [31:0] a, b, result;
  logic        out_valid, out_ready, zero, illegal;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .is_mul(is_mul), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic m,
                       input logic [31:0] aa, input logic [31:0] bb);
    in_valid = 1'b1; alu_op = op; func = f; is_mul = m; a = aa; b = bb;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 4'b0000, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_flags got zero=%b illegal=%b exp 0/0", zero, illegal); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_cycle;
    @(negedge clk) drive(2'b10, 4'b1000, 1'b0, 32'd5, 32'd7);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || zero !== 1'b0 || illegal !== 1'b0) begin
      failures++; $display("FAIL sub got v=%b r=%h z=%b i=%b exp 1/fffffffe/0/0", out_valid, result, zero, illegal); end
    @(negedge clk) drive(2'b11, 4'b1101, 1'b0, 32'h8000_0000, 32'd4);
    @(posedge clk); #1;
    checks++; if (result !== 32'hF800_0000) begin failures++; $display("FAIL srai got=%h exp=f8000000", result); end
    @(negedge clk) drive(2'b11, 4'b0101, 1'b0, 32'h8000_0000, 32'd4);
    @(posedge clk); #1;
    checks++; if (result !== 32'h0800_0000) begin failures++; $display("FAIL srli got=%h exp=08000000", result); end
    @(negedge clk) drive(2'b10, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    checks++; if (result !== 32'd1 || zero !== 1'b0) begin failures++; $display("FAIL slt got r=%h z=%b exp 1/0", result, zero); end
    @(negedge clk) drive(2'b10, 4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    checks++; if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL sltu got r=%h z=%b v=%b exp 0/1/1", result, zero, out_valid); end
  endtask

  task automatic test_backpressure;
    logic bad = 1'b0;
    @(negedge clk) drive(2'b10, 4'b1111, 1'b0, 32'd3, 32'd3);
    @(posedge clk); #1;
    checks++; if (illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL illegal_op got i=%b r=%h z=%b v=%b exp 1/0/1/1", illegal, result, zero, out_valid); end
    @(negedge clk) begin out_ready = 1'b0; drive(2'b00, 4'b0000, 1'b0, 32'd1, 32'd1); end
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL hold_stable got v=%b r=%h i=%b rdy=%b exp 1/0/1/0", out_valid, result, illegal, in_ready); end
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_mul;
`ifdef ALU_MUL_EN
    int  lat = 0;
    logic bad = 1'b0;
    @(negedge clk) drive(2'b10, 4'b0000, 1'b1, 32'd1234, 32'd5678);
    @(posedge clk); #1;
    @(negedge clk) in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = k; break; end
      if (in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (lat != 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", lat); end
    checks++; if (result !== 32'd7006652 || illegal !== 1'b0) begin failures++; $display("FAIL mul_result got=%0d i=%b exp 7006652/0", result, illegal); end
    checks++; if (bad) begin failures++; $display("FAIL mul_in_ready got=1 exp=0 while busy"); end
    @(negedge clk) drive(2'b10, 4'b0000, 1'b1, 32'd1234, 32'd5678);
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mul_flush got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
    @(negedge clk) flush = 1'b0;
    bad = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL mul_abort got v=1 exp 0 after flush"); end
`else
    @(negedge clk) drive(2'b10, 4'b0000, 1'b1, 32'd1234, 32'd5678);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1) begin
      failures++; $display("FAIL mul_disabled got v=%b r=%h z=%b i=%b exp 1/0/1/1", out_valid, result, zero, illegal); end
`endif
    @(negedge clk) drive(2'b00, 4'b0000, 1'b1, 32'd2, 32'd3);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd5 || illegal !== 1'b0) begin
      failures++; $display("FAIL mul_ignored got v=%b r=%h i=%b exp 1/5/0", out_valid, result, illegal); end
  endtask

  task automatic test_flush_accept;
    @(negedge clk) begin drive(2'b00, 4'b0000, 1'b0, 32'd9, 32'd1); flush = 1'b1; end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || result !== 32'd5) begin
      failures++; $display("FAIL flush_accept got v=%b r=%h exp 0/5", out_valid, result); end
    @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; end
  endtask

  task automatic test_reset_mid;
`ifdef ALU_MUL_EN
    @(negedge clk) drive(2'b10, 4'b0000, 1'b1, 32'd1234, 32'd5678);
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
      failures++; $display("FAIL reset_mul got v=%b rdy=%b r=%h exp 0/1/0", out_valid, in_ready, result); end
    @(negedge clk) rst_n = 1'b1;
`endif
    @(negedge clk) drive(2'b00, 4'b0000, 1'b0, 32'd6, 32'd7);
    @(posedge clk);
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b0; end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd13) begin failures++; $display("FAIL pre_reset got v=%b r=%h exp 1/d", out_valid, result); end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_held got v=%b r=%h z=%b i=%b rdy=%b exp 0/0/0/0/1", out_valid, result, zero, illegal, in_ready); end
    @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  v_op [10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
    logic [3:0]  v_fn [10] = '{4'b1111, 4'b0000, 4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b1000, 4'b0101, 4'b0010, 4'b0011};
    logic [31:0] v_a  [10] = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd1, 32'd10, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] v_b  [10] = '{32'd1, 32'd5, 32'hFF00, 32'h0F0F, 32'h0F, 32'd33, 32'd20, 32'd31, 32'd3, 32'd3};
    logic [31:0] v_e  [10] = '{32'd0, 32'hFFFF_FFFE, 32'hF000, 32'hFFFF, 32'hF0, 32'd2, 32'd30, 32'd1, 32'd1, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) drive(v_op[i], v_fn[i], 1'b0, v_a[i], v_b[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== v_e[i] || zero !== (v_e[i] == 32'd0) || in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_%0d got v=%b r=%h z=%b rdy=%b exp r=%h", i, out_valid, result, zero, in_ready, v_e[i]); end
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_backpressure;
    test_mul;
    test_flush_accept;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
